idix_stage: RTL



---
 rtl/upipe_pkg.sv | 30 +++
 rtl/hazard_scoreboard.sv | 48 ++++
 rtl/idix_stage.sv | 139 +++++++++++++
 3 files changed

// File: rtl/upipe_pkg.sv
// Shared types for the uRISC decode/execute boundary: the registered idix bus and scoreboard entries.
package upipe_pkg;
    localparam int UOP_W     = 26;
    localparam int REG_IDX_W = 3;
    localparam int IMM_LSB   = 2;
    localparam int IMM_MSB   = 17;
    localparam int WORD_W    = 16;

    typedef struct packed {
        logic [WORD_W-1:0]    inst;
        logic [4:0]           opcode;
        logic [UOP_W-1:0]     uop_cnt;
        logic                 execute_valid;
        logic                 ldst_valid;
        logic                 jmp;
        logic                 branch;
        logic                 jmp_displacement;
        logic                 rotate_shift_right;
        logic                 reg_write_valid;
        logic [REG_IDX_W-1:0] dest_reg;
        logic [WORD_W-1:0]    rs;
        logic [WORD_W-1:0]    rt;
        logic [WORD_W-1:0]    pc;
    } idix_bus_t;

    typedef struct packed {
        logic                 wr_valid;
        logic [REG_IDX_W-1:0] dest;
    } sb_entry_t;
endpackage

// File: rtl/hazard_scoreboard.sv
// Shadow of in-flight destinations past execute; flags a RAW hazard combinationally.
// Shadow shifts on every non-stalled cycle and freezes while execute is stalled.
module hazard_scoreboard
    import upipe_pkg::*;
#(
    parameter int SB_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 stage_valid,
    input  logic                 stage_wr,
    input  logic [REG_IDX_W-1:0] stage_dest,
    input  logic                 dec_valid,
    input  logic                 rs_used,
    input  logic                 rt_used,
    input  logic [REG_IDX_W-1:0] rs_sel,
    input  logic [REG_IDX_W-1:0] rt_sel,
    output logic                 hazard
);
    sb_entry_t shadow [SB_DEPTH];
    logic      rs_hit;
    logic      rt_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else if (!stall) begin
            shadow[0].wr_valid <= stage_valid & stage_wr;
            shadow[0].dest     <= stage_dest;
            for (int i = 1; i < SB_DEPTH; i++) begin
                shadow[i] <= shadow[i-1];
            end
        end
    end

    always_comb begin
        rs_hit = stage_valid & stage_wr & (stage_dest == rs_sel);
        rt_hit = stage_valid & stage_wr & (stage_dest == rt_sel);
        for (int i = 0; i < SB_DEPTH; i++) begin
            rs_hit = rs_hit | (shadow[i].wr_valid & (shadow[i].dest == rs_sel));
            rt_hit = rt_hit | (shadow[i].wr_valid & (shadow[i].dest == rt_sel));
        end
        hazard = dec_valid & ((rs_used & rs_hit) | (rt_used & rt_hit));
    end
endmodule

// File: rtl/idix_stage.sv
// Decode-to-execute register with RAW interlock, stall hold and deferred flush; 1-cycle load latency.
// ix_stall freezes the stage and stalls decode; a flush seen during a stall is applied once, on release.
module idix_stage
    import upipe_pkg::*;
#(
    parameter int SB_DEPTH = 2,
    parameter int DATA_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [15:0]          dec_inst,
    input  logic [4:0]           dec_opcode,
    input  logic [UOP_W-1:0]     dec_uop_cnt,
    input  logic                 dec_execute_valid,
    input  logic                 dec_ldst_valid,
    input  logic                 dec_jmp,
    input  logic                 dec_branch,
    input  logic                 dec_jmp_displacement,
    input  logic                 dec_rotate_shift_right,
    input  logic                 dec_reg_write_valid,
    input  logic [REG_IDX_W-1:0] dec_dest_reg,
    input  logic [REG_IDX_W-1:0] dec_rs_sel,
    input  logic [REG_IDX_W-1:0] dec_rt_sel,
    input  logic                 dec_rs_used,
    input  logic                 dec_rt_used,
    input  logic [15:0]          dec_pc,
    input  logic [DATA_W-1:0]    rf_rs_data,
    input  logic [DATA_W-1:0]    rf_rt_data,
    input  logic                 ix_stall,
    input  logic                 flush,
    output logic                 dec_stall,
    output logic                 idix_valid_p1,
    output logic [15:0]          inst_idix_p1,
    output logic [4:0]           opcode_idix_p1,
    output logic [UOP_W-1:0]     uop_cnt_idix_p1,
    output logic                 execute_valid_idix_p1,
    output logic                 ldst_valid_idix_p1,
    output logic                 jmp_idix_p1,
    output logic                 branch_idix_p1,
    output logic                 jmp_displacement_idix_p1,
    output logic                 rotate_shift_right_idix_p1,
    output logic                 reg_write_valid_idix_p1,
    output logic [REG_IDX_W-1:0] dest_reg_idix_p1,
    output logic [DATA_W-1:0]    rs_p1,
    output logic [DATA_W-1:0]    rt_p1,
    output logic [15:0]          pc_p1,
    output logic [15:0]          hazard_stall_cnt
);
    idix_bus_t   stage_q;
    idix_bus_t   load_bus;
    logic        valid_q;
    logic        flush_pending_q;
    logic [15:0] hazard_cnt_q;
    logic        hazard;
    logic        fl;

    hazard_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .stall       (ix_stall),
        .stage_valid (valid_q),
        .stage_wr    (stage_q.reg_write_valid),
        .stage_dest  (stage_q.dest_reg),
        .dec_valid   (dec_valid),
        .rs_used     (dec_rs_used),
        .rt_used     (dec_rt_used),
        .rs_sel      (dec_rs_sel),
        .rt_sel      (dec_rt_sel),
        .hazard      (hazard)
    );

    always_comb begin
        fl        = flush | flush_pending_q;
        dec_stall = ix_stall | (hazard & ~fl & ~rst);
        load_bus  = '0;
        if (dec_valid) begin
            load_bus.inst               = dec_inst;
            load_bus.opcode             = dec_opcode;
            load_bus.uop_cnt            = dec_uop_cnt;
            load_bus.execute_valid      = dec_execute_valid;
            load_bus.ldst_valid         = dec_ldst_valid;
            load_bus.jmp                = dec_jmp;
            load_bus.branch             = dec_branch;
            load_bus.jmp_displacement   = dec_jmp_displacement;
            load_bus.rotate_shift_right = dec_rotate_shift_right;
            load_bus.reg_write_valid    = dec_reg_write_valid;
            load_bus.dest_reg           = dec_dest_reg;
            load_bus.rs                 = rf_rs_data;
            load_bus.rt                 = rf_rt_data;
            load_bus.pc                 = dec_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q         <= '0;
            valid_q         <= 1'b0;
            flush_pending_q <= 1'b0;
            hazard_cnt_q    <= '0;
        end else if (ix_stall) begin
            if (flush) begin
                flush_pending_q <= 1'b1;
            end
        end else begin
            flush_pending_q <= 1'b0;
            if (fl) begin
                stage_q <= '0;
                valid_q <= 1'b0;
            end else if (hazard) begin
                stage_q <= '0;
                valid_q <= 1'b0;
                if (hazard_cnt_q != 16'hFFFF) begin
                    hazard_cnt_q <= hazard_cnt_q + 16'd1;
                end
            end else begin
                stage_q <= load_bus;
                valid_q <= dec_valid;
            end
        end
    end

    assign idix_valid_p1              = valid_q;
    assign inst_idix_p1               = stage_q.inst;
    assign opcode_idix_p1             = stage_q.opcode;
    assign uop_cnt_idix_p1            = stage_q.uop_cnt;
    assign execute_valid_idix_p1      = stage_q.execute_valid;
    assign ldst_valid_idix_p1         = stage_q.ldst_valid;
    assign jmp_idix_p1                = stage_q.jmp;
    assign branch_idix_p1             = stage_q.branch;
    assign jmp_displacement_idix_p1   = stage_q.jmp_displacement;
    assign rotate_shift_right_idix_p1 = stage_q.rotate_shift_right;
    assign reg_write_valid_idix_p1    = stage_q.reg_write_valid;
    assign dest_reg_idix_p1           = stage_q.dest_reg;
    assign rs_p1                      = stage_q.rs;
    assign rt_p1                      = stage_q.rt;
    assign pc_p1                      = stage_q.pc;
    assign hazard_stall_cnt           = hazard_cnt_q;
endmodule
